// File: rtl/systolic_ws_array_pkg.sv
// Shared sizing constants and weight-load FSM encoding for the systolic array.
package systolic_ws_array_pkg;
  localparam int sys_rows   = 4;
  localparam int sys_cols   = 4;
  localparam int A_BITWIDTH = 8;
  localparam int W_BITWIDTH = 8;
  localparam int P_BITWIDTH = 32;

  typedef enum logic [1:0] {FILL, FULL, DRAIN} wfsm_t;
endpackage

// File: rtl/systolic_ws_array_pe.sv
// Weight-stationary PE: double-buffered weight, MAC into a registered partial
// sum, and pass registers for activation, valid and swap tag.
module ws_pe #(
  parameter int A_W = 8,
  parameter int W_W = 8,
  parameter int P_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a_in,
  input  logic           vld_in,
  input  logic           tag_in,
  input  logic [P_W-1:0] p_in,
  input  logic           w_shift,
  input  logic [W_W-1:0] w_sh_in,
  output logic [A_W-1:0] a_out,
  output logic           vld_out,
  output logic           tag_out,
  output logic [P_W-1:0] p_out,
  output logic [W_W-1:0] w_sh_out
);
  logic [W_W-1:0]             w_act, w_sh, w_use;
  logic signed [A_W+W_W-1:0]  prod;

  // The tagged vector already uses the new weight on the cycle it arrives.
  assign w_use    = tag_in ? w_sh : w_act;
  assign prod     = $signed(a_in) * $signed(w_use);
  assign w_sh_out = w_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out   <= '0;
      vld_out <= 1'b0;
      tag_out <= 1'b0;
      p_out   <= '0;
      w_act   <= '0;
      w_sh    <= '0;
    end else begin
      a_out   <= a_in;
      vld_out <= vld_in;
      tag_out <= tag_in;
      if (vld_in) p_out <= p_in + {{(P_W-A_W-W_W){prod[A_W+W_W-1]}}, prod};
      if (w_shift) w_sh <= w_sh_in;
      if (tag_in) w_act <= w_sh;
    end
  end
endmodule

// File: rtl/systolic_ws_array.sv
// Weight-stationary systolic array with input skew, output deskew, per-column
// bias, weight-load FSM with tagged swap, and optional ReLU.
module systolic_ws_array
  import systolic_ws_array_pkg::*;
#(
  parameter int ROWS = sys_rows,
  parameter int COLS = sys_cols,
  parameter int A_W  = A_BITWIDTH,
  parameter int W_W  = W_BITWIDTH,
  parameter int P_W  = P_BITWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_valid,
  input  logic [COLS*W_W-1:0] w_row,
  output logic                w_ready,
  output logic                w_loaded,
  input  logic                a_valid,
  input  logic [ROWS*A_W-1:0] a_data,
  input  logic                a_swap,
  input  logic [COLS*P_W-1:0] bias,
  input  logic                relu_en,
  output logic                swap_err,
  output logic                o_valid,
  output logic [COLS*P_W-1:0] o_data
);
  localparam int CW = $clog2(ROWS+COLS) + 1;

  wfsm_t         state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          beat, tag_inj;

  assign w_ready  = (state == FILL);
  assign w_loaded = (state == FULL);
  assign beat     = w_valid & w_ready;
  assign tag_inj  = a_valid & a_swap & w_loaded;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      FILL: if (beat) begin
        if (cnt == CW'(ROWS-1)) begin state_nxt = FULL; cnt_nxt = '0; end
        else cnt_nxt = cnt + 1'b1;
      end
      FULL: if (tag_inj) begin state_nxt = DRAIN; cnt_nxt = '0; end
      DRAIN: begin
        // Hold off new loads until the tag has reached the last PE.
        if (cnt == CW'(ROWS+COLS-2)) begin state_nxt = FILL; cnt_nxt = '0; end
        else cnt_nxt = cnt + 1'b1;
      end
      default: begin state_nxt = FILL; cnt_nxt = '0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= '0;
      swap_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      swap_err <= a_valid & a_swap & ~w_loaded;
    end
  end

  logic [ROWS-1:0][COLS:0][A_W-1:0] a_h;
  logic [ROWS-1:0][COLS:0]          v_h, t_h;
  logic [ROWS:0][COLS-1:0][P_W-1:0] p_v;
  logic [ROWS:0][COLS-1:0][W_W-1:0] w_v;
  logic [COLS-1:0][P_W-1:0]         col_out;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    if (gi == 0) begin : g_nosk
      assign {v_h[0][0], t_h[0][0], a_h[0][0]} = {a_valid, tag_inj, a_data[A_W-1:0]};
    end else begin : g_sk
      logic [gi-1:0][A_W+1:0] sk;
      always_ff @(posedge clk) begin
        if (rst) sk <= '0;
        else begin
          sk[0] <= {a_valid, tag_inj, a_data[gi*A_W +: A_W]};
          for (int k = 1; k < gi; k++) sk[k] <= sk[k-1];
        end
      end
      assign {v_h[gi][0], t_h[gi][0], a_h[gi][0]} = sk[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_col
    assign w_v[0][gj] = w_row[gj*W_W +: W_W];
    if (gj == 0) begin : g_nosk
      assign p_v[0][0] = bias[P_W-1:0];
    end else begin : g_sk
      logic [gj-1:0][P_W-1:0] sk;
      always_ff @(posedge clk) begin
        if (rst) sk <= '0;
        else begin
          sk[0] <= bias[gj*P_W +: P_W];
          for (int k = 1; k < gj; k++) sk[k] <= sk[k-1];
        end
      end
      assign p_v[0][gj] = sk[gj-1];
    end

    if (gj == COLS-1) begin : g_nodsk
      assign col_out[gj] = p_v[ROWS][gj];
    end else begin : g_dsk
      logic [COLS-2-gj:0][P_W-1:0] dsk;
      always_ff @(posedge clk) begin
        if (rst) dsk <= '0;
        else begin
          dsk[0] <= p_v[ROWS][gj];
          for (int k = 1; k <= COLS-2-gj; k++) dsk[k] <= dsk[k-1];
        end
      end
      assign col_out[gj] = dsk[COLS-2-gj];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_gr
    for (genvar gj = 0; gj < COLS; gj++) begin : g_gc
      ws_pe #(.A_W(A_W), .W_W(W_W), .P_W(P_W)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_h[gi][gj]),
        .vld_in   (v_h[gi][gj]),
        .tag_in   (t_h[gi][gj]),
        .p_in     (p_v[gi][gj]),
        .w_shift  (beat),
        .w_sh_in  (w_v[gi][gj]),
        .a_out    (a_h[gi][gj+1]),
        .vld_out  (v_h[gi][gj+1]),
        .tag_out  (t_h[gi][gj+1]),
        .p_out    (p_v[gi+1][gj]),
        .w_sh_out (w_v[gi+1][gj])
      );
    end
  end

  // The bottom-right PE's valid lines up with every deskewed column.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= v_h[ROWS-1][COLS];
      if (v_h[ROWS-1][COLS])
        for (int j = 0; j < COLS; j++)
          o_data[j*P_W +: P_W] <= (relu_en && col_out[j][P_W-1]) ? '0 : col_out[j];
    end
  end
endmodule

// File: tb/tb_systolic_ws_array.sv
// Scoreboard bench: a matrix-level model predicts each output vector at issue
// time; a negedge monitor pops and compares whenever o_valid is seen.
module tb_systolic_ws_array;
  import systolic_ws_array_pkg::*;
  localparam int R = sys_rows, C = sys_cols;
  localparam int AW = A_BITWIDTH, WW = W_BITWIDTH, PW = P_BITWIDTH;

  logic clk = 0, rst = 1;
  logic w_valid = 0, a_valid = 0, a_swap = 0, relu_en = 0;
  logic [C*WW-1:0] w_row = '0;
  logic [R*AW-1:0] a_data = '0;
  logic [C*PW-1:0] bias = '0;
  logic w_ready, w_loaded, swap_err, o_valid;
  logic [C*PW-1:0] o_data;

  systolic_ws_array dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_row(w_row), .w_ready(w_ready),
    .w_loaded(w_loaded), .a_valid(a_valid), .a_data(a_data), .a_swap(a_swap),
    .bias(bias), .relu_en(relu_en), .swap_err(swap_err), .o_valid(o_valid), .o_data(o_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [C*PW-1:0] expq[$];
  int sh[R][C], act[R][C], mat[R][C];
  int mst, beats, dcnt;   // mst: 0 filling, 1 loaded, 2 draining
  int va[R], vb[C], wr[C];

  task automatic chk(string nm, logic [C*PW-1:0] got, logic [C*PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(bit av, bit sw, bit wv);
    a_valid = av; a_swap = sw; w_valid = wv;
    for (int i = 0; i < R; i++) a_data[i*AW +: AW] = AW'(va[i]);
    for (int j = 0; j < C; j++) bias[j*PW +: PW] = PW'(vb[j]);
    for (int j = 0; j < C; j++) w_row[j*WW +: WW] = WW'(wr[j]);
  endtask

  // Predict effect of the currently driven inputs, then advance one clock.
  task automatic cyc();
    logic [C*PW-1:0] e;
    bit use_new, exp_se;
    int s;
    exp_se  = a_valid && a_swap && (mst != 1);
    use_new = a_valid && a_swap && (mst == 1);
    if (a_valid) begin
      for (int j = 0; j < C; j++) begin
        s = vb[j];
        for (int i = 0; i < R; i++) s += va[i] * (use_new ? sh[i][j] : act[i][j]);
        if (relu_en && s < 0) s = 0;
        e[j*PW +: PW] = PW'(s);
      end
      expq.push_back(e);
    end
    if (mst == 0) begin
      if (w_valid) begin
        for (int r = R-1; r > 0; r--) for (int j = 0; j < C; j++) sh[r][j] = sh[r-1][j];
        for (int j = 0; j < C; j++) sh[0][j] = wr[j];
        beats++;
        if (beats == R) begin mst = 1; beats = 0; end
      end
    end else if (mst == 1) begin
      if (use_new) begin
        for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) act[r][j] = sh[r][j];
        mst = 2; dcnt = 0;
      end
    end else begin
      dcnt++;
      if (dcnt == R+C-1) mst = 0;
    end
    @(posedge clk); #1;
    chk("w_ready", w_ready, mst == 0);
    chk("w_loaded", w_loaded, mst == 1);
    chk("swap_err", swap_err, exp_se);
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    expq.delete();
    for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) begin sh[r][j] = 0; act[r][j] = 0; end
    mst = 0; beats = 0; dcnt = 0;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_w_loaded", w_loaded, 0);
    chk("rst_swap_err", swap_err, 0);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < R; i++) va[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < C; j++) vb[j] = int'($urandom);
  endtask

  // Beat k carries matrix row R-1-k; optionally stream random vectors alongside.
  task automatic load_mat(bit stream);
    for (int k = 0; k < R; k++) begin
      for (int j = 0; j < C; j++) wr[j] = mat[R-1-k][j];
      if (stream) rand_vec();
      drive(stream, 0, 1);
      cyc();
    end
    drive(0, 0, 0);
  endtask

  task automatic set_identity();
    for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) mat[r][j] = (r == j) ? 1 : 0;
  endtask

  task automatic swap_vec();
    drive(1, 1, 0); cyc(); drive(0, 0, 0);
  endtask

  task automatic flush();
    int n = 0;
    drive(0, 0, 0);
    while ((expq.size() != 0 || mst == 2) && n < 60) begin cyc(); n++; end
    if (expq.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL flush: got %0d pending outputs expected 0", expq.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (expq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL o_valid: got unexpected output %h expected none", o_data);
      end else chk("o_data", o_data, expq.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < R; i++) va[i] = 0;
    for (int j = 0; j < C; j++) begin vb[j] = 0; wr[j] = 0; end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // identity load and exact-latency check
    set_identity(); load_mat(0);
    for (int i = 0; i < R; i++) va[i] = i + 1;
    for (int j = 0; j < C; j++) vb[j] = 10 * (j + 1);
    swap_vec();
    for (int k = 0; k < R+C-2; k++) begin cyc(); chk("latency_early", o_valid, 0); end
    cyc();
    chk("latency_valid", o_valid, 1);
    chk("identity_const", o_data, {32'd44, 32'd33, 32'd22, 32'd11});
    flush();

    for (int n = 0; n < 10; n++) begin rand_vec(); drive(1, 0, 0); cyc(); end
    flush();

    // load all-2 while streaming; swap on vector 6
    for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) mat[r][j] = 2;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < R; i++) va[i] = int'($urandom_range(0, 20)) - 10;
      for (int j = 0; j < C; j++) vb[j] = 0;
      if (c < R) for (int j = 0; j < C; j++) wr[j] = mat[R-1-c][j];
      drive(1, c == 6, c < R);
      cyc();
    end
    flush();

    // wrap
    for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) mat[r][j] = -128;
    load_mat(0);
    for (int i = 0; i < R; i++) va[i] = -128;
    for (int j = 0; j < C; j++) vb[j] = 32'h7fff_ffff;
    swap_vec(); flush();

    // ReLU on a column sum of -5, then without ReLU
    for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) mat[r][j] = (r == 0) ? -5 : 0;
    load_mat(0);
    relu_en = 1;
    va[0] = 1; for (int i = 1; i < R; i++) va[i] = 0;
    for (int j = 0; j < C; j++) vb[j] = 0;
    swap_vec(); flush();
    chk("relu_on", o_data, '0);
    relu_en = 0;
    drive(1, 0, 0); cyc(); flush();
    chk("relu_off", o_data, {4{32'hFFFF_FFFB}});

    // swap after only 2 beats: error pulse, old weights stay active
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < C; j++) wr[j] = int'($urandom_range(0, 255)) - 128;
      drive(0, 0, 1); cyc();
    end
    rand_vec(); swap_vec();
    rand_vec(); drive(1, 0, 0); cyc();
    flush();

    // reset while vectors are in flight, then reload identity
    for (int n = 0; n < 5; n++) begin rand_vec(); drive(1, 0, 0); cyc(); end
    do_reset();
    repeat (12) cyc();
    set_identity(); load_mat(0);
    for (int i = 0; i < R; i++) va[i] = i + 1;
    for (int j = 0; j < C; j++) vb[j] = 10 * (j + 1);
    swap_vec(); flush();
    chk("reset_reload", o_data, {32'd44, 32'd33, 32'd22, 32'd11});

    // random weights, random ReLU, streaming
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) mat[r][j] = int'($urandom_range(0, 255)) - 128;
      relu_en = $urandom_range(0, 1);
      load_mat(1);
      rand_vec(); swap_vec();
      for (int n = 0; n < 8; n++) begin rand_vec(); drive(1, 0, 0); cyc(); end
      flush();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
